// File: rtl/turn_if.sv
// Signal bundle between the turn controller and its host: coin/key conditioning
// and tile judge on one side, display/debug consumers of the outputs on the other.
interface turn_if #(
  parameter int NUM_PLAYERS = 2,
  parameter int GOAL        = 12
);
  localparam int IDW = (NUM_PLAYERS > 2) ? $clog2(NUM_PLAYERS) : 1;
  localparam int PW  = $clog2(GOAL + 1);

  logic                      coin;
  logic                      key;
  logic                      judge_valid;
  logic                      judge_go;
  logic                      reveal;
  logic                      move;
  logic                      turn_end;
  logic                      timeout;
  logic [IDW-1:0]            cur_player;
  logic [NUM_PLAYERS*PW-1:0] pos_flat;
  logic                      win;
  logic [IDW-1:0]            winner;
  logic [2:0]                state;

  // host side: drives coin/key/judge, observes game outputs
  modport master (
    output coin, key, judge_valid, judge_go,
    input  reveal, move, turn_end, timeout, cur_player, pos_flat, win, winner, state
  );

  // controller side
  modport slave (
    input  coin, key, judge_valid, judge_go,
    output reveal, move, turn_end, timeout, cur_player, pos_flat, win, winner, state
  );
endinterface

// File: rtl/turn_controller.sv
// Multi-player turn sequencer for Chicken Cha-Cha-Cha.
// Coin arms the game, each key press requests a tile reveal, the judge answers
// match (token advances, same player keeps going) or miss (turn passes).
// First token to reach GOAL wins; a new coin restarts from WIN.
// Optional build macro TURN_TIMEOUT_EN: forced pass after TIMEOUT_CYC idle
// cycles in WAIT_KEY. Without it the timeout output is tied low.

// One player's token position; clears on game start, saturates at GOAL.
module turn_pos_lane #(
  parameter int GOAL = 12,
  parameter int PW   = 4
) (
  input  logic          CLK,
  input  logic          RST_N,
  input  logic          clr,
  input  logic          inc,
  output logic [PW-1:0] pos,
  output logic          at_goal
);
  assign at_goal = (pos == PW'(GOAL));

  // position register, never wraps past GOAL
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N)                pos <= '0;
    else if (clr)              pos <= '0;
    else if (inc && !at_goal)  pos <= pos + PW'(1);
  end
endmodule

module turn_controller #(
  parameter int NUM_PLAYERS = 2,
  parameter int GOAL        = 12,
  parameter int TIMEOUT_CYC = 1000000
) (
  input logic   CLK,
  input logic   RST_N,
  turn_if.slave bus
);
  localparam int IDW = (NUM_PLAYERS > 2) ? $clog2(NUM_PLAYERS) : 1;
  localparam int PW  = $clog2(GOAL + 1);

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    WAIT_KEY   = 3'd1,
    REVEAL     = 3'd2,
    WAIT_JUDGE = 3'd3,
    ADVANCE    = 3'd4,
    PASS       = 3'd5,
    WIN        = 3'd7
  } state_t;

  state_t                          st;
  logic                            coin_q, key_q;
  logic                            coin_rise, key_rise;
  logic [IDW-1:0]                  cur, cur_nxt, winner_r;
  logic                            reveal_r, move_r, turn_end_r, timeout_r, win_r;
  logic                            expire;
  logic                            start;
  logic                            hit;
  logic [NUM_PLAYERS-1:0]          inc, at_goal;
  logic [NUM_PLAYERS-1:0][PW-1:0]  pos;

  assign coin_rise = bus.coin & ~coin_q;
  assign key_rise  = bus.key  & ~key_q;
  assign cur_nxt   = (cur == IDW'(NUM_PLAYERS - 1)) ? '0 : cur + IDW'(1);
  // a new game starts only from IDLE or WIN; mid-game coins are dropped
  assign start     = coin_rise && (st == IDLE || st == WIN);
  assign hit       = (st == WAIT_JUDGE) && bus.judge_valid && bus.judge_go;

  // per-player position lanes; only the current player's lane steps on a match
  for (genvar i = 0; i < NUM_PLAYERS; i++) begin : g_lane
    assign inc[i] = hit && (cur == IDW'(i));
    turn_pos_lane #(.GOAL(GOAL), .PW(PW)) u_lane (
      .CLK     (CLK),
      .RST_N   (RST_N),
      .clr     (start),
      .inc     (inc[i]),
      .pos     (pos[i]),
      .at_goal (at_goal[i])
    );
  end

`ifdef TURN_TIMEOUT_EN
  localparam int CW = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
  logic [CW-1:0] tcnt;

  // idle counter; any non-WAIT_KEY cycle clears it, so every entry starts at 0
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N)               tcnt <= '0;
    else if (st == WAIT_KEY)  tcnt <= tcnt + CW'(1);
    else                      tcnt <= '0;
  end

  assign expire = (st == WAIT_KEY) && (tcnt == CW'(TIMEOUT_CYC - 1));
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = |TIMEOUT_CYC;
  assign expire = 1'b0;
`endif

  // turn FSM with registered pulses; pulses default low every cycle
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      st         <= IDLE;
      coin_q     <= 1'b0;
      key_q      <= 1'b0;
      cur        <= '0;
      winner_r   <= '0;
      win_r      <= 1'b0;
      reveal_r   <= 1'b0;
      move_r     <= 1'b0;
      turn_end_r <= 1'b0;
      timeout_r  <= 1'b0;
    end else begin
      coin_q     <= bus.coin;
      key_q      <= bus.key;
      reveal_r   <= 1'b0;
      move_r     <= 1'b0;
      turn_end_r <= 1'b0;
      timeout_r  <= 1'b0;
      case (st)
        IDLE: if (coin_rise) begin
          st  <= WAIT_KEY;
          cur <= '0;
        end
        WAIT_KEY: begin
          // a key press on the expiry cycle still wins over the timeout
          if (key_rise) begin
            st       <= REVEAL;
            reveal_r <= 1'b1;
          end else if (expire) begin
            st         <= PASS;
            turn_end_r <= 1'b1;
            timeout_r  <= 1'b1;
            cur        <= cur_nxt;
          end
        end
        REVEAL: st <= WAIT_JUDGE;
        WAIT_JUDGE: if (bus.judge_valid) begin
          if (bus.judge_go) begin
            st     <= ADVANCE;
            move_r <= 1'b1;
          end else begin
            st         <= PASS;
            turn_end_r <= 1'b1;
            cur        <= cur_nxt;
          end
        end
        // lane already holds the stepped position here
        ADVANCE: begin
          if (at_goal[cur]) begin
            st       <= WIN;
            win_r    <= 1'b1;
            winner_r <= cur;
          end else begin
            st <= WAIT_KEY;
          end
        end
        PASS: st <= WAIT_KEY;
        WIN: if (coin_rise) begin
          st       <= WAIT_KEY;
          win_r    <= 1'b0;
          winner_r <= '0;
          cur      <= '0;
        end
        default: st <= IDLE;
      endcase
    end
  end

  assign bus.reveal     = reveal_r;
  assign bus.move       = move_r;
  assign bus.turn_end   = turn_end_r;
  assign bus.timeout    = timeout_r;
  assign bus.cur_player = cur;
  assign bus.pos_flat   = pos;
  assign bus.win        = win_r;
  assign bus.winner     = winner_r;
  assign bus.state      = st;
endmodule

// File: tb/tb_turn_controller.sv
// Directed bench for turn_controller (2 players, GOAL=12, TIMEOUT_CYC=8).
// A game-level model predicts every output each cycle; literal checks pin key moments.
module tb_turn_controller;
  localparam int NP   = 2;
  localparam int GOAL = 12;
  localparam int TO   = 8;
  localparam int PW   = $clog2(GOAL + 1);

  logic CLK = 1'b0;
  logic RST_N = 1'b0;
  int   checks = 0;
  int   errors = 0;
  int   n_reveal = 0, n_move = 0, n_tend = 0, n_tout = 0;

  turn_if #(.NUM_PLAYERS(NP), .GOAL(GOAL)) bus ();

  turn_controller #(.NUM_PLAYERS(NP), .GOAL(GOAL), .TIMEOUT_CYC(TO)) dut (
    .CLK   (CLK),
    .RST_N (RST_N),
    .bus   (bus)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- game model ----------------
  int m_phase;            // spec state code the game is in
  int m_cur, m_winner, m_waited;
  int m_pos [NP];
  bit m_win, m_reveal, m_move, m_tend, m_tout;
  bit m_cq, m_kq;

  always @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      m_phase = 0; m_cur = 0; m_winner = 0; m_waited = 0; m_win = 0;
      m_reveal = 0; m_move = 0; m_tend = 0; m_tout = 0; m_cq = 0; m_kq = 0;
      foreach (m_pos[i]) m_pos[i] = 0;
    end else begin
      bit coin_up, key_up;
      coin_up = bus.coin && !m_cq;
      key_up  = bus.key && !m_kq;
      m_cq = bus.coin; m_kq = bus.key;
      m_reveal = 0; m_move = 0; m_tend = 0; m_tout = 0;
      if ((m_phase == 0 || m_phase == 7) && coin_up) begin
        m_phase = 1; m_cur = 0; m_win = 0; m_winner = 0; m_waited = 0;
        foreach (m_pos[i]) m_pos[i] = 0;
      end else if (m_phase == 1) begin
        m_waited++;
        if (key_up) begin
          m_phase = 2; m_reveal = 1;
        end
`ifdef TURN_TIMEOUT_EN
        else if (m_waited == TO) begin
          m_phase = 5; m_tend = 1; m_tout = 1; m_cur = (m_cur + 1) % NP;
        end
`endif
      end else if (m_phase == 2) begin
        m_phase = 3;
      end else if (m_phase == 3 && bus.judge_valid) begin
        if (bus.judge_go) begin
          m_phase = 4; m_move = 1;
          if (m_pos[m_cur] < GOAL) m_pos[m_cur]++;
        end else begin
          m_phase = 5; m_tend = 1; m_cur = (m_cur + 1) % NP;
        end
      end else if (m_phase == 4) begin
        if (m_pos[m_cur] == GOAL) begin
          m_phase = 7; m_win = 1; m_winner = m_cur;
        end else begin
          m_phase = 1; m_waited = 0;
        end
      end else if (m_phase == 5) begin
        m_phase = 1; m_waited = 0;
      end
    end
  end

  function automatic logic [NP*PW-1:0] model_flat();
    logic [NP*PW-1:0] f;
    f = '0;
    for (int i = 0; i < NP; i++) f[i*PW +: PW] = PW'(m_pos[i]);
    return f;
  endfunction

  // compare every cycle away from the active edge, and tally pulses
  always @(negedge CLK) begin
    if (RST_N) begin
      chk("state",      32'(bus.state),      32'(m_phase));
      chk("reveal",     32'(bus.reveal),     32'(m_reveal));
      chk("move",       32'(bus.move),       32'(m_move));
      chk("turn_end",   32'(bus.turn_end),   32'(m_tend));
      chk("timeout",    32'(bus.timeout),    32'(m_tout));
      chk("cur_player", 32'(bus.cur_player), 32'(m_cur));
      chk("pos_flat",   32'(bus.pos_flat),   32'(model_flat()));
      chk("win",        32'(bus.win),        32'(m_win));
      chk("winner",     32'(bus.winner),     32'(m_winner));
      n_reveal += int'(bus.reveal);
      n_move   += int'(bus.move);
      n_tend   += int'(bus.turn_end);
      n_tout   += int'(bus.timeout);
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick(input int n);
    repeat (n) @(negedge CLK);
  endtask

  task automatic pulse_coin();
    bus.coin = 1'b1; tick(1); bus.coin = 1'b0; tick(1);
  endtask

  // full turn from WAIT_KEY: press, wait past REVEAL, judge, settle
  task automatic do_turn(input bit go);
    bus.key = 1'b1; tick(1);
    bus.key = 1'b0; tick(1);
    bus.judge_valid = 1'b1; bus.judge_go = go; tick(1);
    bus.judge_valid = 1'b0; bus.judge_go = 1'b0; tick(1);
  endtask

  initial begin
    int r0, m0;
    bus.coin = 1'b0; bus.key = 1'b0; bus.judge_valid = 1'b0; bus.judge_go = 1'b0;
    tick(3);
    #1 RST_N = 1'b1;
    tick(1);
    chk("rst_state", 32'(bus.state), 32'd0);
    chk("rst_pos",   32'(bus.pos_flat), 32'd0);
    chk("rst_win",   32'(bus.win), 32'd0);

    // key / judge in IDLE are ignored
    bus.key = 1'b1; bus.judge_valid = 1'b1; bus.judge_go = 1'b1; tick(1);
    bus.key = 1'b0; bus.judge_valid = 1'b0; bus.judge_go = 1'b0; tick(2);
    chk("idle_ignore", 32'(bus.state), 32'd0);

    // match for player 0
    pulse_coin();
    chk("armed", 32'(bus.state), 32'd1);
    bus.key = 1'b1; tick(1);
    chk("reveal_lat", 32'(bus.reveal), 32'd1);
    bus.key = 1'b0; tick(1);
    chk("reveal_once", 32'(bus.reveal), 32'd0);
    bus.judge_valid = 1'b1; bus.judge_go = 1'b1; tick(1);
    chk("move_pulse", 32'(bus.move), 32'd1);
    bus.judge_valid = 1'b0; bus.judge_go = 1'b0; tick(1);
    chk("pos0_one", 32'(bus.pos_flat[3:0]), 32'd1);
    chk("cur_stays", 32'(bus.cur_player), 32'd0);
    chk("move_count", 32'(n_move), 32'd1);

    // miss by player 0 then by player 1 wraps back to 0
    do_turn(1'b0);
    chk("cur_to_1", 32'(bus.cur_player), 32'd1);
    bus.key = 1'b1; tick(1); bus.key = 1'b0; tick(1);
    bus.judge_valid = 1'b1; bus.judge_go = 1'b0; tick(1);
    chk("pass_pulse", 32'(bus.turn_end), 32'd1);
    chk("cur_wrap", 32'(bus.cur_player), 32'd0);
    bus.judge_valid = 1'b0; tick(1);

    // held key counts once; judge during REVEAL and coin mid-game ignored
    r0 = n_reveal;
    bus.key = 1'b1; tick(1);
    bus.judge_valid = 1'b1; bus.judge_go = 1'b1; tick(1);
    bus.judge_valid = 1'b0; bus.judge_go = 1'b0;
    chk("judge_in_reveal", 32'(bus.state), 32'd3);
    tick(48);
    bus.key = 1'b0; tick(1);
    chk("held_key_once", 32'(n_reveal - r0), 32'd1);
    pulse_coin();
    chk("no_restart", 32'(bus.state), 32'd3);
    bus.judge_valid = 1'b1; bus.judge_go = 1'b0; tick(1);
    bus.judge_valid = 1'b0; tick(1);

    // async reset while waiting for the judge
    bus.key = 1'b1; tick(1); bus.key = 1'b0; tick(1);
    chk("pre_rst_state", 32'(bus.state), 32'd3);
    chk("pre_rst_pos", 32'(bus.pos_flat), 32'd1);
    #3 RST_N = 1'b0;
    #1;
    chk("arst_state", 32'(bus.state), 32'd0);
    chk("arst_pos", 32'(bus.pos_flat), 32'd0);
    chk("arst_pulses", 32'({bus.reveal, bus.move, bus.turn_end, bus.timeout, bus.win}), 32'd0);
    chk("arst_cur", 32'(bus.cur_player), 32'd0);
    tick(1);
    #1 RST_N = 1'b1;
    tick(1);

    // player 0 runs to GOAL
    pulse_coin();
    repeat (GOAL) do_turn(1'b1);
    chk("win", 32'(bus.win), 32'd1);
    chk("winner", 32'(bus.winner), 32'd0);
    chk("win_state", 32'(bus.state), 32'd7);
    chk("pos_goal", 32'(bus.pos_flat[3:0]), 32'd12);
    m0 = n_move;
    do_turn(1'b1);
    chk("win_hold", 32'(bus.state), 32'd7);
    chk("win_no_move", 32'(n_move - m0), 32'd0);
    pulse_coin();
    chk("restart_win", 32'(bus.win), 32'd0);
    chk("restart_pos", 32'(bus.pos_flat), 32'd0);
    chk("restart_state", 32'(bus.state), 32'd1);

`ifdef TURN_TIMEOUT_EN
    // WAIT_KEY entered one edge into pulse_coin; expiry on its 8th cycle
    tick(6);
    chk("pre_expire", 32'(bus.timeout), 32'd0);
    tick(1);
    chk("timeout", 32'(bus.timeout), 32'd1);
    chk("timeout_tend", 32'(bus.turn_end), 32'd1);
    chk("timeout_cur", 32'(bus.cur_player), 32'd1);
    tick(8);
    bus.key = 1'b1; tick(1);
    chk("key_beats_to", 32'(bus.reveal), 32'd1);
    chk("key_no_to", 32'(bus.timeout), 32'd0);
    bus.key = 1'b0; tick(3);
    chk("timeout_count", 32'(n_tout), 32'd1);
`else
    tick(20);
    chk("no_timeout_state", 32'(bus.state), 32'd1);
    chk("no_timeout", 32'(n_tout), 32'd0);
`endif

    tick(2);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
